// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder sequencer: default widths,
// FSM state encoding and result bypass selections.
package fp_add_pkg;

   localparam int EXP_W_DFLT  = 8;
   localparam int MANT_W_DFLT = 24;
   localparam int CNT_W_DFLT  = 5;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] BYP_NONE = 2'd0;
   localparam logic [1:0] BYP_A    = 2'd1;
   localparam logic [1:0] BYP_B    = 2'd2;
   localparam logic [1:0] BYP_ZERO = 2'd3;

   // An Inf/NaN operand dominates; otherwise a zero operand passes the other one through.
   function automatic logic [1:0] bypass_sel(input logic special_a, input logic special_b,
                                             input logic zero_a, input logic zero_b);
      logic [1:0] sel;
      if (special_a) begin
         sel = BYP_A;
      end else if (special_b) begin
         sel = BYP_B;
      end else if (zero_a) begin
         sel = BYP_B;
      end else if (zero_b) begin
         sel = BYP_A;
      end else begin
         sel = BYP_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/fp_exp_diff.sv
// Exponent comparator: picks the larger exponent, flags a swap when B is larger,
// and produces the alignment shift count clamped to one past the mantissa width.
module fp_exp_diff
   import fp_add_pkg::*;
#(
   parameter int EXP_W  = EXP_W_DFLT,
   parameter int MANT_W = MANT_W_DFLT,
   parameter int CNT_W  = CNT_W_DFLT
) (
   input  logic [EXP_W-1:0] exp_a_i,
   input  logic [EXP_W-1:0] exp_b_i,
   output logic             swap_o,
   output logic [EXP_W-1:0] max_exp_o,
   output logic [CNT_W-1:0] shift_cnt_o
);

   localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MANT_W + 1);

   logic [EXP_W-1:0] diff_s;

   // Compare, subtract larger minus smaller, clamp the shift distance.
   always_comb begin
      swap_o = (exp_b_i > exp_a_i);
      if (swap_o) begin
         max_exp_o = exp_b_i;
         diff_s    = exp_b_i - exp_a_i;
      end else begin
         max_exp_o = exp_a_i;
         diff_s    = exp_a_i - exp_b_i;
      end
      if (diff_s > MAX_SHIFT) begin
         shift_cnt_o = CNT_W'(MANT_W + 1);
      end else begin
         shift_cnt_o = CNT_W'(diff_s);
      end
   end

endmodule

// File: rtl/fp_add_sequencer.sv
// Control FSM for the multi-cycle floating-point adder: accepts an operand pair,
// steps alignment, addition and normalization, and tracks the result exponent and flags.
module fp_add_sequencer
   import fp_add_pkg::*;
#(
   parameter int EXP_W  = EXP_W_DFLT,
   parameter int MANT_W = MANT_W_DFLT,
   parameter int CNT_W  = CNT_W_DFLT
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [EXP_W-1:0] Exp_A,
   input  logic [EXP_W-1:0] Exp_B,
   input  logic             Special_A,
   input  logic             Special_B,
   input  logic             Zero_A,
   input  logic             Zero_B,
   input  logic             Sum_Carry,
   input  logic             Sum_Msb,
   input  logic             Sum_Zero,
   output logic             Load_Ops,
   output logic             Swap,
   output logic             Align_Shift,
   output logic             Add_En,
   output logic             Norm_Shr,
   output logic             Norm_Shl,
   output logic [1:0]       Bypass_Sel,
   output logic [EXP_W-1:0] Res_Exp,
   output logic             Overflow,
   output logic             Underflow,
   output logic             Out_Valid,
   input  logic             Out_Ready
);

   localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] SHL_MAX  = CNT_W'(MANT_W - 1);

   state_t           state_q, state_d;
   logic             swap_q, swap_d;
   logic [EXP_W-1:0] res_exp_q, res_exp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [1:0]       byp_q, byp_d;

   logic             swap_s;
   logic [EXP_W-1:0] max_exp_s;
   logic [CNT_W-1:0] shift_cnt_s;
   logic [1:0]       byp_new_s;
   logic             load_s, shr_s, shl_s;

   fp_exp_diff #(
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W),
      .CNT_W  (CNT_W)
   ) u_exp_diff (
      .exp_a_i     (Exp_A),
      .exp_b_i     (Exp_B),
      .swap_o      (swap_s),
      .max_exp_o   (max_exp_s),
      .shift_cnt_o (shift_cnt_s)
   );

   assign byp_new_s = bypass_sel(Special_A, Special_B, Zero_A, Zero_B);

   // State and result registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         swap_q    <= 1'b0;
         res_exp_q <= {EXP_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         byp_q     <= BYP_NONE;
      end else begin
         state_q   <= state_d;
         swap_q    <= swap_d;
         res_exp_q <= res_exp_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         byp_q     <= byp_d;
      end
   end

   // Next-state, register updates and the input-dependent strobes.
   always_comb begin
      state_d   = state_q;
      swap_d    = swap_q;
      res_exp_d = res_exp_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      byp_d     = byp_q;
      load_s    = 1'b0;
      shr_s     = 1'b0;
      shl_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (In_Valid) begin
               load_s    = 1'b1;
               swap_d    = swap_s;
               res_exp_d = max_exp_s;
               cnt_d     = shift_cnt_s;
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
               byp_d     = byp_new_s;
               if (byp_new_s != BYP_NONE) begin
                  state_d = S_DONE;
               end else if (shift_cnt_s == {CNT_W{1'b0}}) begin
                  state_d = S_ADD;
               end else begin
                  state_d = S_ALIGN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ALIGN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_ADD;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ADD: begin
            // The counter is reused to bound left-shifts in NORM.
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_NORM;
         end
         S_NORM: begin
            if (Sum_Zero) begin
               byp_d     = BYP_ZERO;
               res_exp_d = {EXP_W{1'b0}};
               state_d   = S_DONE;
            end else if (Sum_Carry) begin
               shr_s   = 1'b1;
               state_d = S_DONE;
               if (res_exp_q == EXP_ONES) begin
                  ovf_d = 1'b1;
               end else begin
                  res_exp_d = res_exp_q + EXP_ONE;
                  ovf_d     = (res_exp_q == (EXP_ONES - EXP_ONE));
               end
            end else if (!Sum_Msb) begin
               if ((res_exp_q > EXP_ONE) && (cnt_q < SHL_MAX)) begin
                  shl_s     = 1'b1;
                  res_exp_d = res_exp_q - EXP_ONE;
                  cnt_d     = cnt_q + CNT_ONE;
                  state_d   = S_NORM;
               end else if (res_exp_q == EXP_ONE) begin
                  unf_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (Out_Ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign In_Ready    = (state_q == S_IDLE);
   assign Out_Valid   = (state_q == S_DONE);
   assign Align_Shift = (state_q == S_ALIGN);
   assign Add_En      = (state_q == S_ADD);
   assign Load_Ops    = load_s;
   assign Norm_Shr    = shr_s;
   assign Norm_Shl    = shl_s;
   assign Swap        = swap_q;
   assign Res_Exp     = res_exp_q;
   assign Overflow    = ovf_q;
   assign Underflow   = unf_q;
   assign Bypass_Sel  = byp_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: a cycle-timeline model of each operation
// is compared against the DUT strobes and results on every cycle.
module tb_fp_add_sequencer;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       In_Valid, In_Ready;
   logic [7:0] Exp_A, Exp_B;
   logic       Special_A, Special_B, Zero_A, Zero_B;
   logic       Sum_Carry, Sum_Msb, Sum_Zero;
   logic       Load_Ops, Swap, Align_Shift, Add_En, Norm_Shr, Norm_Shl;
   logic [1:0] Bypass_Sel;
   logic [7:0] Res_Exp;
   logic       Overflow, Underflow, Out_Valid, Out_Ready;

   int checks   = 0;
   int failures = 0;

   fp_add_sequencer dut (
      .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .Exp_A(Exp_A), .Exp_B(Exp_B), .Special_A(Special_A), .Special_B(Special_B),
      .Zero_A(Zero_A), .Zero_B(Zero_B), .Sum_Carry(Sum_Carry), .Sum_Msb(Sum_Msb),
      .Sum_Zero(Sum_Zero), .Load_Ops(Load_Ops), .Swap(Swap), .Align_Shift(Align_Shift),
      .Add_En(Add_En), .Norm_Shr(Norm_Shr), .Norm_Shl(Norm_Shl), .Bypass_Sel(Bypass_Sel),
      .Res_Exp(Res_Exp), .Overflow(Overflow), .Underflow(Underflow),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] strobes();
      return {In_Ready, Load_Ops, Align_Shift, Add_En, Norm_Shl, Norm_Shr, Out_Valid};
   endfunction

   function automatic logic [12:0] result();
      return {Res_Exp, Swap, Overflow, Underflow, Bypass_Sel};
   endfunction

   task automatic run_op(input string name, input int a, input int b,
                         input logic sa, input logic sb, input logic za, input logic zb,
                         input int need, input logic carry, input logic zero,
                         input int lit_res, input int lit_lat,
                         input int stall, input logic hold_valid, input int abort_at);
      int e, d, cnt, s, lim, res, lat, rem, k;
      logic isbyp, swp, ovf, unf, shr, shl_prev, done;
      logic [1:0] byp;
      logic [6:0] exp_str;
      logic [12:0] exp_res;
      // Model: timeline and final result derived from the operation's arithmetic.
      isbyp = sa | sb | za | zb;
      byp   = sa ? 2'd1 : sb ? 2'd2 : za ? 2'd2 : zb ? 2'd1 : 2'd0;
      swp   = (b > a);
      e     = swp ? b : a;
      d     = swp ? b - a : a - b;
      cnt   = (d > 25) ? 25 : d;
      s = 0; ovf = 1'b0; unf = 1'b0; shr = 1'b0; res = e;
      if (isbyp) begin
         lat = 1; cnt = 0;
      end else if (zero) begin
         res = 0; byp = 2'd3; lat = 3 + cnt;
      end else if (carry) begin
         shr = 1'b1;
         res = (e == 255) ? 255 : e + 1;
         ovf = (res == 255);
         lat = 3 + cnt;
      end else begin
         lim = (e > 0) ? e - 1 : 0;
         s   = need;
         if (s > 23) s = 23;
         if (s > lim) s = lim;
         res = e - s;
         unf = (need > s) && (res == 1);
         lat = 3 + cnt + s;
      end
      chk({name, "_model_res"}, res, lit_res);
      chk({name, "_model_lat"}, lat, lit_lat);
      exp_res = {res[7:0], swp, ovf, unf, byp};

      rem = need; shl_prev = 1'b0; done = 1'b0; k = 0;
      Sum_Carry = carry; Sum_Zero = zero;
      while (!done) begin
         @(negedge Clk);
         if (shl_prev) rem--;
         Sum_Msb = (rem <= 0);
         if (k == 0) begin
            In_Valid = 1'b1; Exp_A = 8'(a); Exp_B = 8'(b);
            Special_A = sa; Special_B = sb; Zero_A = za; Zero_B = zb;
         end else begin
            In_Valid = hold_valid; Exp_A = 8'(a) ^ 8'hFF; Exp_B = 8'(b) ^ 8'h0F;
         end
         Out_Ready = (k >= lat + stall);
         if (k == abort_at) begin
            Rst = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
            #1;
            chk({name, "_async_rst_strobes"}, strobes(), 7'b1000000);
            chk({name, "_async_rst_result"}, result(), 13'd0);
            @(negedge Clk);
            Rst = 1'b0;
            return;
         end
         #1;
         exp_str = {k == 0, k == 0,
                    !isbyp && k >= 1 && k <= cnt,
                    !isbyp && k == cnt + 1,
                    !isbyp && !zero && !carry && k >= cnt + 2 && k < cnt + 2 + s,
                    shr && k == cnt + 2,
                    k >= lat};
         chk($sformatf("%s_strobes_k%0d", name, k), strobes(), exp_str);
         if (k >= lat) chk($sformatf("%s_result_k%0d", name, k), result(), exp_res);
         shl_prev = Norm_Shl;
         if (Out_Valid && Out_Ready) done = 1'b1;
         k++;
         if (!done && k > 200) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no handshake after %0d cycles, expected at %0d", name, k, lat);
            done = 1'b1;
         end
      end
      @(negedge Clk);
      In_Valid = 1'b0; Out_Ready = 1'b0; Sum_Carry = 1'b0; Sum_Zero = 1'b0; Sum_Msb = 1'b0;
      Special_A = 1'b0; Special_B = 1'b0; Zero_A = 1'b0; Zero_B = 1'b0;
      #1;
      chk({name, "_back_idle"}, {In_Ready, Out_Valid}, 2'b10);
   endtask

   initial begin
      Rst = 1'b1; In_Valid = 1'b0; Exp_A = 8'd0; Exp_B = 8'd0;
      Special_A = 1'b0; Special_B = 1'b0; Zero_A = 1'b0; Zero_B = 1'b0;
      Sum_Carry = 1'b0; Sum_Msb = 1'b0; Sum_Zero = 1'b0; Out_Ready = 1'b0;
      #1;
      chk("reset_strobes", strobes(), 7'b1000000);
      chk("reset_result", result(), 13'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b0;

      //      name         a    b   sa    sb    za    zb  need carry zero  res lat stall hold abort
      run_op("eq_carry",  127, 127, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 128,  3, 0, 1'b0, -1);
      run_op("align3",    130, 127, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 130,  6, 0, 1'b0, -1);
      run_op("clamp25",    10, 200, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 200, 28, 0, 1'b0, -1);
      run_op("shl4",      100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0,  96,  7, 0, 1'b0, -1);
      run_op("underflow",   2,   2, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0,   1,  4, 0, 1'b0, -1);
      run_op("shl_bound", 100, 100, 1'b0, 1'b0, 1'b0, 1'b0,30, 1'b0, 1'b0,  77, 26, 0, 1'b0, -1);
      run_op("overflow",  254, 254, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 255,  3, 0, 1'b0, -1);
      run_op("ovf_hold",  255, 255, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 255,  3, 0, 1'b0, -1);
      run_op("ovf_align", 254, 250, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 255,  7, 0, 1'b0, -1);
      run_op("byp_spB",    50,  60, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0,  60,  1, 0, 1'b0, -1);
      run_op("byp_spA",   200,   3, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 200,  1, 0, 1'b0, -1);
      run_op("byp_zeroB",   5,   9, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0,   9,  1, 0, 1'b0, -1);
      run_op("sum_zero",  120, 118, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1,   0,  5, 0, 1'b0, -1);
      run_op("stall",     130, 127, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 130,  6, 5, 1'b1, -1);
      run_op("abort",     140, 127, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 140, 16, 0, 1'b0,  4);
      run_op("rerun",     130, 127, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 130,  6, 0, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
Multi-cycle control FSM for the 32-bit floating-point adder datapath. Accepts an operand pair and computes exponent difference and swap. Sequences mantissa alignment, add, and normalization through the datapath's 8-bit mux/shift/add resources. Tracks the result exponent and flags overflow/underflow, with a valid/ready handshake on both sides.

Parameters:
EXP_W, 8, exponent width
MANT_W, 24, mantissa width incl. hidden bit
CNT_W, 5, alignment/normalize counter width (must hold MANT_W+1)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-high reset
In_Valid  in  1  operand pair valid
In_Ready  out  1  high only in IDLE
Exp_A  in  EXP_W  biased exponent of A
Exp_B  in  EXP_W  biased exponent of B
Special_A  in  1  A is Inf/NaN
Special_B  in  1  B is Inf/NaN
Zero_A  in  1  A is zero
Zero_B  in  1  B is zero
Sum_Carry  in  1  registered mantissa sum carry-out
Sum_Msb  in  1  registered sum bit MANT_W-1
Sum_Zero  in  1  registered sum all-zero
Load_Ops  out  1  capture operands in datapath
Swap  out  1  select for exponent/mantissa muxes: 1 = B larger
Align_Shift  out  1  shift smaller mantissa right by 1
Add_En  out  1  register mantissa sum
Norm_Shr  out  1  shift sum right by 1
Norm_Shl  out  1  shift sum left by 1
Bypass_Sel  out  2  0 normal, 1 pass A, 2 pass B, 3 zero
Res_Exp  out  EXP_W  result exponent
Overflow  out  1  result exponent saturated to all-ones
Underflow  out  1  normalization stopped at Res_Exp==1
Out_Valid  out  1  result valid
Out_Ready  in  1  consumer accepts

Behaviour:
- Reset: state IDLE; all outputs 0 except In_Ready=1.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- Pulse outputs (Load_Ops, Align_Shift, Add_En, Norm_Shr, Norm_Shl) are Moore/Mealy single-cycle strobes, 0 outside the cases below.

IDLE:
- In_Ready=1; on In_Valid: Load_Ops=1 that cycle.
- Register Swap=(Exp_B>Exp_A), Res_Exp=max(Exp_A,Exp_B), and cnt=min(|Exp_A-Exp_B|, MANT_W+1).
- Clear Overflow/Underflow/Bypass_Sel.
- Bypass priority, checked in the accept cycle:
  - Special_A -> Bypass_Sel=1
  - else Special_B -> 2
  - else Zero_A -> 2
  - else Zero_B -> 1
- Any bypass -> DONE; else cnt==0 -> ADD; else ALIGN.

ALIGN:
- Align_Shift=1 every cycle; cnt decrements.
- Leave for ADD after the cycle in which cnt==1.

ADD:
- Add_En=1 for one cycle -> NORM.

NORM (decides on Sum_* each cycle):
- Sum_Zero: Bypass_Sel=3, Res_Exp=0 -> DONE.
- Sum_Carry:
  - Norm_Shr=1, Res_Exp+1 -> DONE.
  - If the incremented value equals all-ones, set Overflow=1.
  - Res_Exp already all-ones: hold it and set Overflow.
- !Sum_Msb and Res_Exp>1: Norm_Shl=1, Res_Exp-1, stay in NORM. Bounded at MANT_W-1 shifts, then DONE.
- !Sum_Msb and Res_Exp==1: Underflow=1 -> DONE, no shift.
- Sum_Msb: -> DONE.

DONE:
- Out_Valid=1; Res_Exp, flags, Swap and Bypass_Sel held stable.
- Out_Ready -> IDLE. Out_Valid and In_Ready are never both high.

Latency:
- Normal path: Out_Valid rises 3 + cnt + left-shift count cycles after accept.
- Bypass: Out_Valid rises 1 cycle after accept.

Boundaries:
- Exponent difference ≥25 clamps to 25 shifts.
- Out_Ready held low stalls DONE indefinitely; In_Valid is ignored outside IDLE.
- Rst mid-operation returns to IDLE and clears all outputs asynchronously; the next operation is unaffected.

Decomposition:
- Shared package fp_add_pkg: state encoding, EXP_W/MANT_W defaults, BYP_NONE/BYP_A/BYP_B/BYP_ZERO constants.
- One sub-module: fp_exp_diff. Combinational compare/subtract/clamp producing swap, max exponent and clamped shift count.

Test Plan:
1. Exp_A=Exp_B=127, no specials, Sum_Carry=1 in NORM -> Swap=0, no Align_Shift, Add_En at cycle 1, Norm_Shr at cycle 2, Res_Exp=128, Out_Valid at cycle 3.
2. Exp_A=130, Exp_B=127 -> Swap=0, Align_Shift cycles 1-3, Add_En cycle 4, Sum_Msb=1 gives Out_Valid cycle 6, Res_Exp=130.
3. Exp_A=10, Exp_B=200 -> Swap=1, exactly 25 Align_Shift pulses, Res_Exp=200.
4. Exp_A=Exp_B=100, Sum_Msb low for 4 NORM cycles -> 4 Norm_Shl, Res_Exp=96. With Res_Exp=2 and 5 shifts needed -> 1 Norm_Shl, Underflow=1, Res_Exp=1.
5. Exp_A=254, Sum_Carry=1 -> Res_Exp=255, Overflow=1. Special_B=1 with Zero_A=1 -> Bypass_Sel=2, Out_Valid 1 cycle after accept.
6. Out_Ready low 5 cycles in DONE -> outputs stable, In_Ready=0. Rst asserted mid-ALIGN -> immediate IDLE, all outputs 0, then a clean rerun of scenario 2.
